// File: rtl/div_arbiter_if.sv
// Bundles the requester, response and shared-divider signals of div_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system
// (requesters, response consumer and the divider itself).
interface div_arbiter_if #(
    parameter int WIDTH = 32
);
    // requester 0 / 1
    logic                 rq0_valid;
    logic                 rq1_valid;
    logic [2*WIDTH-1:0]   rq0_numerator;
    logic [2*WIDTH-1:0]   rq1_numerator;
    logic [WIDTH-1:0]     rq0_denominator;
    logic [WIDTH-1:0]     rq1_denominator;
    logic                 rq0_ready;
    logic                 rq1_ready;
    // response
    logic                 rsp_valid;
    logic                 rsp_id;
    logic [WIDTH-1:0]     rsp_quotient;
    logic [WIDTH-1:0]     rsp_remainder;
    logic [1:0]           rsp_fault;
    // shared divider
    logic                 div_start;
    logic [2*WIDTH-1:0]   div_numerator;
    logic [WIDTH-1:0]     div_denominator;
    logic [WIDTH-1:0]     div_quotient;
    logic [WIDTH-1:0]     div_remainder;
    logic                 div_done;

    modport slave (
        input  rq0_valid, rq1_valid, rq0_numerator, rq1_numerator,
               rq0_denominator, rq1_denominator,
        output rq0_ready, rq1_ready,
        output rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_fault,
        output div_start, div_numerator, div_denominator,
        input  div_quotient, div_remainder, div_done
    );

    modport master (
        output rq0_valid, rq1_valid, rq0_numerator, rq1_numerator,
               rq0_denominator, rq1_denominator,
        input  rq0_ready, rq1_ready,
        input  rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_fault,
        input  div_start, div_numerator, div_denominator,
        output div_quotient, div_remainder, div_done
    );
endinterface

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a single shared divider.
// Operands are pre-checked for divide-by-zero and quotient overflow at grant
// time so bad operations never reach the divider; a watchdog bounds both the
// wait for the divider to go busy and the wait for it to finish.
module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    div_arbiter_if.slave bus
);
    // Watchdog counts 0..TIMEOUT-1; the wait expires in the cycle it holds TIMEOUT-1.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_DIVZERO = 2'd1;
    localparam logic [1:0] CODE_OVFL    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, FAULT
    } state_t;

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 id_q, id_d;
    logic [2*WIDTH-1:0]   num_q, num_d;
    logic [WIDTH-1:0]     den_q, den_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     rsp_quo_q, rsp_quo_d;
    logic [WIDTH-1:0]     rsp_rem_q, rsp_rem_d;
    logic [1:0]           rsp_fault_q, rsp_fault_d;

    logic                 gnt_id;
    logic [2*WIDTH-1:0]   sel_num;
    logic [WIDTH-1:0]     sel_den;

    // Round-robin pick: on a contest, the requester not granted last wins.
    always_comb begin
        gnt_id = 1'b0;
        if (bus.rq0_valid && bus.rq1_valid) begin
            gnt_id = ~last_grant_q;
        end else begin
            gnt_id = bus.rq1_valid;
        end
        sel_num = gnt_id ? bus.rq1_numerator   : bus.rq0_numerator;
        sel_den = gnt_id ? bus.rq1_denominator : bus.rq0_denominator;
    end

    // Next-state, grant, divider strobe and response loading.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        num_d         = num_q;
        den_d         = den_q;
        wd_d          = wd_q;
        rsp_valid_d   = 1'b0;
        rsp_id_d      = rsp_id_q;
        rsp_quo_d     = rsp_quo_q;
        rsp_rem_d     = rsp_rem_q;
        rsp_fault_d   = rsp_fault_q;
        bus.rq0_ready = 1'b0;
        bus.rq1_ready = 1'b0;
        bus.div_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.div_done && (bus.rq0_valid || bus.rq1_valid)) begin
                    bus.rq0_ready = ~gnt_id;
                    bus.rq1_ready = gnt_id;
                    last_grant_d  = gnt_id;
                    id_d          = gnt_id;
                    num_d         = sel_num;
                    den_d         = sel_den;
                    wd_d          = '0;
                    if (sel_den == '0 || sel_num[2*WIDTH-1:WIDTH] >= sel_den) begin
                        // Rejected operations answer next cycle without touching the divider.
                        state_d     = FAULT;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = gnt_id;
                        rsp_quo_d   = '0;
                        rsp_rem_d   = '0;
                        rsp_fault_d = (sel_den == '0) ? CODE_DIVZERO : CODE_OVFL;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                bus.div_start = 1'b1;
                wd_d          = '0;
                state_d       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.div_done) begin
                    wd_d    = '0;
                    state_d = WAIT_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d     = FAULT;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = '0;
                    rsp_rem_d   = '0;
                    rsp_fault_d = CODE_TIMEOUT;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            WAIT_DONE: begin
                if (bus.div_done) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = bus.div_quotient;
                    rsp_rem_d   = bus.div_remainder;
                    rsp_fault_d = CODE_OK;
                end else if (wd_q == WD_LAST) begin
                    state_d     = FAULT;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_quo_d   = '0;
                    rsp_rem_d   = '0;
                    rsp_fault_d = CODE_TIMEOUT;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            RESP:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            num_q        <= '0;
            den_q        <= '0;
            wd_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_quo_q    <= '0;
            rsp_rem_q    <= '0;
            rsp_fault_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            num_q        <= num_d;
            den_q        <= den_d;
            wd_q         <= wd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_quo_q    <= rsp_quo_d;
            rsp_rem_q    <= rsp_rem_d;
            rsp_fault_q  <= rsp_fault_d;
        end
    end

    assign bus.div_numerator   = num_q;
    assign bus.div_denominator = den_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_quotient    = rsp_quo_q;
    assign bus.rsp_remainder   = rsp_rem_q;
    assign bus.rsp_fault       = rsp_fault_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a small multi-cycle divider model.
module tb_div_arbiter;
    localparam int W  = 32;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    div_arbiter_if #(.WIDTH(W)) bus ();

    div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Divider model: drops done the cycle after start, finishes 3 cycles later.
    // When stuck, it ignores start and keeps done high.
    bit          model_clear = 1'b1;
    bit          stuck       = 1'b0;
    int          busy_cnt    = 0;
    int          start_cnt   = 0;
    logic [2*W-1:0] m_num;
    logic [W-1:0]   m_den;

    always @(posedge clock) begin
        if (bus.div_start) start_cnt <= start_cnt + 1;
        if (model_clear) begin
            bus.div_done      <= 1'b1;
            bus.div_quotient  <= '0;
            bus.div_remainder <= '0;
            busy_cnt          <= 0;
        end else if (bus.div_start && !stuck) begin
            m_num        <= bus.div_numerator;
            m_den        <= bus.div_denominator;
            bus.div_done <= 1'b0;
            busy_cnt     <= 3;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                bus.div_done      <= 1'b1;
                bus.div_quotient  <= W'(m_num / {{W{1'b0}}, m_den});
                bus.div_remainder <= W'(m_num % {{W{1'b0}}, m_den});
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int who, input bit v, input logic [63:0] num, input logic [31:0] den);
        if (who == 0) begin
            bus.rq0_valid = v; bus.rq0_numerator = num; bus.rq0_denominator = den;
        end else begin
            bus.rq1_valid = v; bus.rq1_numerator = num; bus.rq1_denominator = den;
        end
    endtask

    // One complete transaction for requester `who`; exp_lat counts cycles from grant to rsp_valid.
    task automatic serve(input int who, input logic [63:0] num, input logic [31:0] den,
                         input logic [1:0] code, input logic [31:0] q, input logic [31:0] r,
                         input int exp_lat);
        bit got;
        int lat;
        int s0;
        drive_req(who, 1'b1, num, den);
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clock);
            if ((who == 0) ? bus.rq0_ready : bus.rq1_ready) got = 1'b1;
        end
        check($sformatf("ready%0d", who), 64'(got), 64'd1);
        if (!got) begin
            drive_req(who, 1'b0, num, den);
            return;
        end
        check("ready_other_low", 64'((who == 0) ? bus.rq1_ready : bus.rq0_ready), 64'd0);
        check("grant_with_done", 64'(bus.div_done), 64'd1);
        s0  = start_cnt;
        lat = 0;
        got = 1'b0;
        while (lat < 100 && !got) begin
            @(negedge clock);
            lat++;
            if (lat == 1) drive_req(who, 1'b0, num, den);
            if (bus.rsp_valid) got = 1'b1;
        end
        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_id", 64'(bus.rsp_id), 64'(who));
        check("rsp_fault", 64'(bus.rsp_fault), 64'(code));
        check("rsp_quotient", 64'(bus.rsp_quotient), 64'(q));
        check("rsp_remainder", 64'(bus.rsp_remainder), 64'(r));
        check("latency", 64'(lat), 64'(exp_lat));
        check("div_starts", 64'(start_cnt - s0), (code == 2'd1 || code == 2'd2) ? 64'd0 : 64'd1);
        $display("txn rq%0d num=%0h den=%0h -> id=%0d fault=%0d q=%0d r=%0d lat=%0d",
                 who, num, den, bus.rsp_id, bus.rsp_fault, bus.rsp_quotient, bus.rsp_remainder, lat);
    endtask

    initial begin
        bit seen;
        drive_req(0, 1'b0, 64'd0, 32'd0);
        drive_req(1, 1'b0, 64'd0, 32'd0);
        repeat (3) @(negedge clock);
        model_clear = 1'b0;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_div_start", 64'(bus.div_start), 64'd0);
        check("rst_rsp_fault", 64'(bus.rsp_fault), 64'd0);
        check("rst_rsp_quotient", 64'(bus.rsp_quotient), 64'd0);
        check("rst_div_numerator", 64'(bus.div_numerator), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Contest after reset: rq0 first, then rq1 wins the repeated contest, then rq0.
        drive_req(0, 1'b1, 64'd100, 32'd17);
        drive_req(1, 1'b1, 64'd100, 32'd16);
        serve(0, 64'd100, 32'd17, 2'd0, 32'd5, 32'd15, 6);
        drive_req(0, 1'b1, 64'd100, 32'd17);
        serve(1, 64'd100, 32'd16, 2'd0, 32'd6, 32'd4, 6);
        serve(0, 64'd100, 32'd17, 2'd0, 32'd5, 32'd15, 6);

        // Single request, then response fields must hold after the pulse.
        serve(0, 64'd3550, 32'd113, 2'd0, 32'd31, 32'd47, 6);
        @(negedge clock);
        check("rsp_pulse_one_cycle", 64'(bus.rsp_valid), 64'd0);
        check("rsp_hold_quotient", 64'(bus.rsp_quotient), 64'd31);
        check("rsp_hold_remainder", 64'(bus.rsp_remainder), 64'd47);

        // Pre-check faults answer at grant+1 with no divider start.
        serve(1, 64'd100, 32'd0, 2'd1, 32'd0, 32'd0, 1);
        serve(0, (64'd5 << 32) + 64'd7, 32'd5, 2'd2, 32'd0, 32'd0, 1);

        // Divider never goes busy: timeout after TO cycles in WAIT_BUSY.
        stuck = 1'b1;
        serve(0, 64'd3550, 32'd113, 2'd3, 32'd0, 32'd0, TO + 2);
        stuck = 1'b0;
        serve(1, 64'd3550, 32'd113, 2'd0, 32'd31, 32'd47, 6);

        // Reset while waiting for the divider to complete.
        drive_req(0, 1'b1, 64'd3550, 32'd113);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clock);
            if (bus.rq0_ready) seen = 1'b1;
        end
        check("mid_ready0", 64'(seen), 64'd1);
        @(negedge clock);
        drive_req(0, 1'b0, 64'd0, 32'd0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (!bus.div_done) seen = 1'b1;
            else @(negedge clock);
        end
        check("mid_div_busy", 64'(seen), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_rsp_quotient", 64'(bus.rsp_quotient), 64'd0);
        check("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("mid_rst_div_numerator", 64'(bus.div_numerator), 64'd0);
        check("mid_rst_div_start", 64'(bus.div_start), 64'd0);
        reset = 1'b0;
        serve(0, 64'd100, 32'd15, 2'd0, 32'd6, 32'd10, 6);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result word width.
REQ-002 Parameter: TIMEOUT, default 255, max cycles waited on each divider handshake edge.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 rq0_valid, rq1_valid  in  1 each  requester n has an operation pending.
REQ-006 rq0_numerator, rq1_numerator  in  2*WIDTH each  dividend.
REQ-007 rq0_denominator, rq1_denominator  in  WIDTH each  divisor.
REQ-008 rq0_ready, rq1_ready  out  1 each  one-cycle accept pulse.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_id  out  1  requester index the response belongs to.
REQ-011 rsp_quotient, rsp_remainder  out  WIDTH each  result words.
REQ-012 rsp_fault  out  2  0 ok, 1 divide-by-zero, 2 overflow, 3 timeout.
REQ-013 div_start  out  1  start strobe to shared divider.
REQ-014 div_numerator  out  2*WIDTH; div_denominator  out  WIDTH  operands to divider.
REQ-015 div_quotient, div_remainder  in  WIDTH each  divider results.
REQ-016 div_done  in  1  divider idle/complete (high idle, low while busy).

Function
REQ-017 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, FAULT.
REQ-018 IDLE: grant only when div_done==1 and some rqN_valid==1; grant cycle pulses rqN_ready, captures operands and N into internal registers.
REQ-019 Round-robin: both valid -> grant requester not granted last; last_grant resets to 1, so rq0 wins first contest; single valid requester always granted.
REQ-020 Requesters hold valid and operands stable until ready; ready never asserts for both in one cycle.
REQ-021 Grant cycle pre-check: denominator==0 -> FAULT code 1; else numerator upper WIDTH bits >= denominator -> FAULT code 2; else -> ISSUE.
REQ-022 FAULT (one cycle): rsp_valid=1, rsp_id=N, code per REQ-021, quotient=remainder=0; div_start never asserted; -> IDLE.
REQ-023 ISSUE (one cycle): div_start=1; -> WAIT_BUSY.
REQ-024 div_numerator/div_denominator driven from captured registers from ISSUE through WAIT_DONE, stable.
REQ-025 WAIT_BUSY: div_done==0 -> WAIT_DONE; watchdog counter reaching TIMEOUT first -> response code 3.
REQ-026 WAIT_DONE: div_done==1 -> capture div_quotient/div_remainder, -> RESP; counter (cleared on entry) reaching TIMEOUT first -> response code 3.
REQ-027 Timeout response: rsp_valid one cycle, rsp_id=N, rsp_fault=3, quotient=remainder=0; -> IDLE.
REQ-028 RESP (one cycle): rsp_valid=1, rsp_id=N, rsp_fault=0, captured results; -> IDLE.
REQ-029 Latency: fault response in cycle grant+1; div_start in grant+1; rsp_valid one cycle after div_done observed high in WAIT_DONE.
REQ-030 rsp_quotient/rsp_remainder/rsp_id/rsp_fault hold last value when rsp_valid==0.
REQ-031 New grant no earlier than the cycle after rsp_valid (one operation in flight).
REQ-032 rqN_valid dropping before ready: no grant, no state change.

Reset
REQ-033 reset in any state -> IDLE next edge; all outputs 0 (rsp_fault=0, div_start=0), last_grant=1, watchdog=0, captured registers 0.
REQ-034 reset mid-operation discards in-flight operation, no response; next request after reset waits for div_done==1 before grant.

Verification
REQ-035 rq0 3550/113 -> rq0_ready pulse, single div_start, rsp id 0, q=31, r=47, fault 0.
REQ-036 After reset, rq0 100/17 and rq1 100/16 valid same cycle -> rq0 first (q=5 r=15), then rq1 (q=6 r=4); repeat pair -> rq1 served first.
REQ-037 rq1 denominator 0 -> rsp at grant+1, id 1, fault 1, q=r=0, div_start never high.
REQ-038 rq0 numerator (5<<WIDTH)+7, denominator 5 -> fault 2 at grant+1, no div_start.
REQ-039 Divider model keeping div_done high after start, TIMEOUT=8 -> fault 3 after 8 WAIT_BUSY cycles, then next request served normally.
REQ-040 reset asserted during WAIT_DONE -> no rsp_valid, outputs 0 next edge; following 100/15 request -> q=6, r=10.
